// File: rtl/uart_rx_fsm_if.sv
// Receive-side bundle: serial line and frame configuration in, word and status out.
interface uart_rx_fsm_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_in;
  logic [5:0]            prescale;
  logic                  par_en;
  logic                  par_typ;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output rx_in, prescale, par_en, par_typ,
    input  p_data, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  rx_in, prescale, par_en, par_typ,
    output p_data, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver: oversampled start detect with glitch reject, 3-sample majority per bit,
// LSB-first shift, optional parity and stop checks, one-cycle data_valid after the stop bit.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8
) (
  input logic          clk,
  input logic          reset,
  uart_rx_fsm_if.slave rx_if
);
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t         state, state_n;
  logic [5:0]     edge_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [5:0]     p_lat;
  logic           par_en_lat;
  logic           par_typ_lat;
  logic           s0, s1;

  logic [5:0] p_dec;
  logic [5:0] half;
  logic       last_edge;
  logic       resolve;
  logic       vote;
  logic       last_bit;

  assign p_dec     = (rx_if.prescale == 6'd16 || rx_if.prescale == 6'd32) ? rx_if.prescale : 6'd8;
  assign half      = p_lat >> 1;
  assign last_edge = (edge_cnt == p_lat - 6'd1);
  assign resolve   = (edge_cnt == half + 6'd1);
  // Third sample is the live line value at the resolution cycle.
  assign vote      = (s0 & s1) | (s0 & rx_if.rx_in) | (s1 & rx_if.rx_in);
  assign last_bit  = (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign rx_if.busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (!rx_if.rx_in) state_n = START;
      START:  begin
        if (resolve && vote) state_n = IDLE;
        else if (last_edge)  state_n = DATA;
      end
      DATA:   if (last_edge && last_bit) state_n = par_en_lat ? PARITY : STOP;
      PARITY: if (last_edge) state_n = STOP;
      STOP:   if (last_edge) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_cnt         <= '0;
      bit_cnt          <= '0;
      p_lat            <= 6'd8;
      par_en_lat       <= 1'b0;
      par_typ_lat      <= 1'b0;
      s0               <= 1'b1;
      s1               <= 1'b1;
      rx_if.p_data     <= '0;
      rx_if.data_valid <= 1'b0;
      rx_if.par_err    <= 1'b0;
      rx_if.stp_err    <= 1'b0;
    end else begin
      rx_if.data_valid <= 1'b0;

      // The detecting IDLE clock is edge 0 of the start bit.
      if (state == IDLE)
        edge_cnt <= rx_if.rx_in ? 6'd0 : 6'd1;
      else if (state_n == IDLE || last_edge)
        edge_cnt <= '0;
      else
        edge_cnt <= edge_cnt + 6'd1;

      if (state != DATA)
        bit_cnt <= '0;
      else if (last_edge)
        bit_cnt <= last_bit ? '0 : bit_cnt + BCW'(1);

      if (edge_cnt == half - 6'd1) s0 <= rx_if.rx_in;
      if (edge_cnt == half)        s1 <= rx_if.rx_in;

      if (state == IDLE && !rx_if.rx_in) begin
        p_lat         <= p_dec;
        par_en_lat    <= rx_if.par_en;
        par_typ_lat   <= rx_if.par_typ;
        rx_if.par_err <= 1'b0;
        rx_if.stp_err <= 1'b0;
      end

      if (state == DATA && resolve)
        rx_if.p_data <= {vote, rx_if.p_data[DATA_WIDTH-1:1]};
      if (state == PARITY && resolve)
        rx_if.par_err <= (vote != (^rx_if.p_data ^ par_typ_lat));
      if (state == STOP && resolve && !vote)
        rx_if.stp_err <= 1'b1;
      if (state == STOP && last_edge)
        rx_if.data_valid <= !rx_if.par_err && !rx_if.stp_err;
    end
  end
endmodule
